// File: rtl/sobel_window_calc.sv
// rtl/sobel_window_calc.sv - Sobel gradient magnitude over a latched 3x3 window, one row per cycle
module sobel_window_calc #(
  parameter int PIXEL_WIDTH = 8,
  parameter int THRESHOLD   = 0
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     calc_enable,
  input  logic [2:0]               select,
  input  logic [9*PIXEL_WIDTH-1:0] window,
  output logic                     calc_done,
  output logic [PIXEL_WIDTH-1:0]   pixel_out,
  output logic [2:0]               result_sel
);
  localparam int AW = PIXEL_WIDTH + 3;
  localparam int MW = PIXEL_WIDTH + 4;
  localparam logic [MW-1:0] SAT_MAX = MW'((1 << PIXEL_WIDTH) - 1);

  typedef enum logic [2:0] {IDLE, ROW0, ROW1, ROW2, DONE} state_t;

  state_t                   state_q, state_d;
  logic [9*PIXEL_WIDTH-1:0] win_q;
  logic [2:0]               sel_q;
  logic signed [AW-1:0]     gx_q, gx_d, gy_q, gy_d;
  logic [PIXEL_WIDTH-1:0]   pix_q, pix_d;
  logic [2:0]               rsel_q;
  logic signed [AW-1:0]     p [9];
  logic                     start, abort;
  logic [AW-1:0]            abs_x, abs_y;
  logic [MW-1:0]            mag;
  logic [PIXEL_WIDTH-1:0]   sat;
  logic signed [31:0]       sat_int;

  for (genvar k = 0; k < 9; k++) begin : g_unpack
    assign p[k] = $signed({3'b000, win_q[PIXEL_WIDTH*k +: PIXEL_WIDTH]});
  end

  assign start = calc_enable && (select != 3'd0);
  // The select FSM moving on (or dropping enable) invalidates the running window.
  assign abort = !calc_enable || (select != sel_q);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ROW0;
      ROW0:    state_d = abort ? IDLE : ROW1;
      ROW1:    state_d = abort ? IDLE : ROW2;
      ROW2:    state_d = abort ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    calc_done = (state_q == DONE);
  end

  always_comb begin
    gx_d = gx_q;
    gy_d = gy_q;
    case (state_q)
      IDLE: if (start) begin
        gx_d = '0;
        gy_d = '0;
      end
      ROW0: begin
        gx_d = gx_q + p[2] - p[0];
        gy_d = gy_q - (p[0] + (p[1] <<< 1) + p[2]);
      end
      ROW1: gx_d = gx_q + ((p[5] - p[3]) <<< 1);
      ROW2: begin
        gx_d = gx_q + p[8] - p[6];
        gy_d = gy_q + p[6] + (p[7] <<< 1) + p[8];
      end
      default: ;
    endcase
  end

  always_comb begin
    abs_x   = gx_q[AW-1] ? -gx_q : gx_q;
    abs_y   = gy_q[AW-1] ? -gy_q : gy_q;
    mag     = MW'(abs_x) + MW'(abs_y);
    sat     = (mag > SAT_MAX) ? SAT_MAX[PIXEL_WIDTH-1:0] : mag[PIXEL_WIDTH-1:0];
    sat_int = signed'(32'(sat));
    pix_d   = (sat_int < THRESHOLD) ? '0 : sat;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      win_q  <= '0;
      sel_q  <= '0;
      gx_q   <= '0;
      gy_q   <= '0;
      pix_q  <= '0;
      rsel_q <= '0;
    end else begin
      gx_q <= gx_d;
      gy_q <= gy_d;
      if (state_q == IDLE && start) begin
        win_q <= window;
        sel_q <= select;
      end
      if (state_q == DONE) begin
        pix_q  <= pix_d;
        rsel_q <= sel_q;
      end
    end
  end

  assign pixel_out  = pix_q;
  assign result_sel = rsel_q;
endmodule

// File: tb/tb_sobel_window_calc.sv
// tb/tb_sobel_window_calc.sv - scoreboard bench for sobel_window_calc at THRESHOLD 0 and 50
module tb_sobel_window_calc;
  localparam int PW = 8;

  logic            clk = 1'b0;
  logic            n_rst;
  logic            calc_enable;
  logic [2:0]      select;
  logic [9*PW-1:0] window;
  logic            done0, done50;
  logic [PW-1:0]   pix0, pix50;
  logic [2:0]      rs0, rs50;

  always #5 clk = ~clk;

  sobel_window_calc #(.PIXEL_WIDTH(PW), .THRESHOLD(0)) u_dut0 (
    .clk(clk), .n_rst(n_rst), .calc_enable(calc_enable), .select(select), .window(window),
    .calc_done(done0), .pixel_out(pix0), .result_sel(rs0));

  sobel_window_calc #(.PIXEL_WIDTH(PW), .THRESHOLD(50)) u_dut50 (
    .clk(clk), .n_rst(n_rst), .calc_enable(calc_enable), .select(select), .window(window),
    .calc_done(done50), .pixel_out(pix50), .result_sel(rs50));

  typedef struct {
    int cyc;
    int sel;
    int p0;
    int p50;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   m_pix0 = 0, m_pix50 = 0, m_sel = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  // Convolution with the standard Sobel kernels, straight from the definition.
  function automatic int ref_pix(input logic [9*PW-1:0] w, input int thr);
    int gx = 0, gy = 0, mag, r, c, pv;
    for (int k = 0; k < 9; k++) begin
      r  = k / 3;
      c  = k % 3;
      pv = int'(w[PW*k +: PW]);
      gx += (c - 1) * ((r == 1) ? 2 : 1) * pv;
      gy += (r - 1) * ((c == 1) ? 2 : 1) * pv;
    end
    mag = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
    if (mag > (1 << PW) - 1) mag = (1 << PW) - 1;
    return (mag < thr) ? 0 : mag;
  endfunction

  function automatic logic [9*PW-1:0] rand_win(input int lim);
    logic [9*PW-1:0] w;
    for (int k = 0; k < 9; k++) w[PW*k +: PW] = PW'($urandom_range(0, lim));
    return w;
  endfunction

  always @(negedge clk) begin
    bit   exp_done;
    exp_t e;
    if (!n_rst) begin
      m_pix0  = 0;
      m_pix50 = 0;
      m_sel   = 0;
    end
    check("pixel_out_thr0", int'(pix0), m_pix0);
    check("pixel_out_thr50", int'(pix50), m_pix50);
    check("result_sel_thr0", int'(rs0), m_sel);
    check("result_sel_thr50", int'(rs50), m_sel);
    exp_done = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    check("calc_done_thr0", int'(done0), int'(exp_done));
    check("calc_done_thr50", int'(done50), int'(exp_done));
    if (exp_done) begin
      e       = exp_q.pop_front();
      m_pix0  = e.p0;
      m_pix50 = e.p50;
      m_sel   = e.sel;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic calc(input int sel, input logic [9*PW-1:0] w);
    exp_t e;
    calc_enable = 1'b1;
    select      = sel[2:0];
    window      = w;
    e.cyc = cyc + 4;
    e.sel = sel;
    e.p0  = ref_pix(w, 0);
    e.p50 = ref_pix(w, 50);
    exp_q.push_back(e);
    tick();
    window = rand_win(255);
    repeat (4) tick();
  endtask

  task automatic go_idle(input int n);
    calc_enable = 1'b0;
    select      = 3'd0;
    repeat (n) tick();
  endtask

  initial begin
    logic [9*PW-1:0] w;
    int lims[3] = '{15, 63, 255};
    n_rst = 1'b0;
    calc_enable = 1'b0;
    select = 3'd0;
    window = '0;
    repeat (3) tick();
    n_rst = 1'b1;
    tick();

    calc(1, '0);
    go_idle(2);

    w = '0;
    w[PW*2 +: PW] = 8'd10; w[PW*5 +: PW] = 8'd10; w[PW*8 +: PW] = 8'd10;
    calc(1, w);
    w[PW*2 +: PW] = 8'd100; w[PW*5 +: PW] = 8'd100; w[PW*8 +: PW] = 8'd100;
    calc(2, w);
    go_idle(1);
    w = '0;
    w[PW*6 +: PW] = 8'd20; w[PW*7 +: PW] = 8'd20; w[PW*8 +: PW] = 8'd20;
    calc(3, w);
    w = '0;
    w[PW*2 +: PW] = 8'd10;
    calc(4, w);
    go_idle(3);

    for (int s = 1; s <= 4; s++) calc(s, rand_win(lims[s % 3]));
    go_idle(10);

    // Enable dropped while in ROW1
    calc_enable = 1'b1; select = 3'd2; window = rand_win(255);
    tick(); tick();
    calc_enable = 1'b0;
    tick(); tick(); tick();
    // Select changes while in ROW1, then a fresh run for the new select
    calc_enable = 1'b1; select = 3'd2; window = rand_win(255);
    tick(); tick();
    select = 3'd1;
    tick();
    calc(1, rand_win(63));
    go_idle(4);

    for (int i = 0; i < 40; i++) begin
      calc($urandom_range(1, 4), rand_win(lims[$urandom_range(0, 2)]));
      if ($urandom_range(0, 2) == 0) go_idle($urandom_range(1, 3));
    end
    go_idle(3);

    // Reset in ROW2 after a nonzero result
    w = '0;
    w[PW*2 +: PW] = 8'd30; w[PW*5 +: PW] = 8'd30; w[PW*8 +: PW] = 8'd30;
    calc(2, w);
    go_idle(1);
    calc_enable = 1'b1; select = 3'd3; window = rand_win(255);
    tick(); tick(); tick();
    n_rst = 1'b0;
    calc_enable = 1'b0;
    select = 3'd0;
    exp_q.delete();
    #1;
    check("rst_calc_done_thr0", int'(done0), 0);
    check("rst_pixel_out_thr0", int'(pix0), 0);
    check("rst_result_sel_thr0", int'(rs0), 0);
    check("rst_calc_done_thr50", int'(done50), 0);
    check("rst_pixel_out_thr50", int'(pix50), 0);
    check("rst_result_sel_thr50", int'(rs50), 0);
    tick(); tick();
    n_rst = 1'b1;
    repeat (10) tick();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sobel_window_calc.md
Name: sobel_window_calc

Overview:
- Downstream calculation stage of the image input buffer.
- Consumes calc_enable and select from the buffer's pixel-select FSM, plus the 3x3 window the buffer muxes out for that select.
- Computes one Sobel gradient magnitude per window over a fixed multi-cycle schedule. Returns a one-cycle calc_done pulse that advances the select FSM to the next window (select 1..4 per loaded block).

Parameters:
PIXEL_WIDTH, 8, bits per pixel; window is 9*PIXEL_WIDTH bits wide; accumulators are signed PIXEL_WIDTH+3 bits.
THRESHOLD, 0, magnitudes strictly below this value are output as 0.

Ports:
clk  input  1  clock, rising edge
n_rst  input  1  reset, asynchronous, active-low
calc_enable  input  1  high while the select FSM holds a valid window (states S0..S3)
select  input  3  window index from select FSM: 0 = none, 1..4 = window 1..4
window  input  9*PIXEL_WIDTH  3x3 window, row-major; pixel k (k = 0..8, p0 top-left) at bits [PIXEL_WIDTH*k +: PIXEL_WIDTH]
calc_done  output  1  one-cycle pulse: result for latched select is ready
pixel_out  output  PIXEL_WIDTH  saturated, thresholded gradient magnitude; holds until the next completion
result_sel  output  3  select value the current pixel_out belongs to

Behaviour:
- Reset: n_rst is asynchronous, active-low; clock is clk. On reset: state = IDLE, calc_done = 0, pixel_out = 0, result_sel = 0, all accumulators and latched window/select = 0.
- States: IDLE, ROW0, ROW1, ROW2, DONE.
- IDLE:
  - If calc_enable = 1 and select != 0, latch window and select, clear Gx and Gy, go to ROW0.
  - Otherwise stay in IDLE.
- ROW0 (latched p0,p1,p2): Gx += p2 - p0; Gy -= p0 + 2*p1 + p2.
- ROW1 (p3,p5): Gx += 2*(p5 - p3); Gy unchanged.
- ROW2 (p6,p7,p8): Gx += p8 - p6; Gy += p6 + 2*p7 + p8. Go to DONE.
- Abort: in ROW0, ROW1 or ROW2, if calc_enable = 0 or select != latched select, go to IDLE. On abort: no calc_done, and pixel_out/result_sel are unchanged.
- DONE:
  - calc_done = 1 (Moore output, exactly one cycle).
  - On the clock edge leaving DONE: pixel_out <= result; result_sel <= latched select. Go to IDLE unconditionally; no abort check in DONE.
  - pixel_out and result_sel are registered at that same edge, so they are valid from the cycle after calc_done.
- Result arithmetic:
  - mag = |Gx| + |Gy|, unsigned PIXEL_WIDTH+4 bits.
  - Saturate to 2^PIXEL_WIDTH - 1.
  - If the saturated value is < THRESHOLD, result = 0.
  - Signed accumulators never overflow: range is +/-4*(2^PIXEL_WIDTH - 1).
- Latency: start edge (IDLE sampling enable) -> ROW0 -> ROW1 -> ROW2 -> DONE. calc_done is high in the 4th cycle after the start cycle; 5 cycles per window including the IDLE turnaround.
- Handshake with the select FSM:
  - The select FSM advances on the same edge at which calc_done is high.
  - The next cycle this block is back in IDLE and sees the new select, or calc_enable = 0 after window 4.
  - The block never restarts with the stale select.
- Window is sampled only at start; later changes to window do not affect the running calculation.
- Reset mid-operation: immediate return to reset values; any pending result is discarded.

Test Plan:
1. Reset, then calc_enable = 1, select = 1, window all zero -> calc_done pulses exactly 4 cycles after the start cycle; pixel_out = 0, result_sel = 1.
2. Vertical edge, right column (p2,p5,p8) = 10, rest 0 -> Gx = 40, Gy = 0, pixel_out = 40. Same pattern with value 100 -> Gx = 400, saturated pixel_out = 255.
3. Bottom row (p6,p7,p8) = 20, rest 0 -> pixel_out = 80. Only p2 = 10 -> Gx = 10, Gy = -10, pixel_out = 20.
4. Full block: emulate the select FSM stepping select 1 -> 2 -> 3 -> 4 on each calc_done, then calc_enable = 0 -> exactly four calc_done pulses 5 cycles apart, result_sel = 1, 2, 3, 4 in order, and the block stays in IDLE afterwards.
5. Abort: in ROW1, drop calc_enable for one cycle -> no calc_done, pixel_out unchanged. Then in ROW1, change select 2 -> 1 -> no calc_done for 2; a fresh 5-cycle calculation for select = 1 completes.
6. THRESHOLD = 50 build: window giving magnitude 40 -> pixel_out = 0. Then assert n_rst low during ROW2 -> calc_done = 0, pixel_out = 0, result_sel = 0 immediately, with no pulse after release.
